// File: rtl/regfile_dump_reader_pkg.sv
// Shared register-file geometry and dump-reader state encodings.
package regfile_dump_reader_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a contiguous register range through an async read port and streams
// (address, value) pairs on a valid/ready interface.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_fptr, w_fptr_nxt;
  logic [ADDR_W-1:0]   r_lreg, w_lreg_nxt;
  logic [ADDR_W-1:0]   r_out_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_out_data, w_data_nxt;
  logic                r_out_valid, w_valid_nxt;
  logic                r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_fptr      <= '0;
      r_lreg      <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fptr      <= w_fptr_nxt;
      r_lreg      <= w_lreg_nxt;
      r_out_addr  <= w_addr_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      // done is registered off the DONE state so it has no input path
      r_done      <= (r_state == ST_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fptr_nxt  = r_fptr;
    w_lreg_nxt  = r_lreg;
    w_addr_nxt  = r_out_addr;
    w_data_nxt  = r_out_data;
    w_valid_nxt = r_out_valid;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            w_fptr_nxt  = first_reg;
            w_lreg_nxt  = last_reg;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        if (abort) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_data_nxt  = rf_rd;
          w_addr_nxt  = r_fptr;
          w_valid_nxt = 1'b1;
          w_fptr_nxt  = r_fptr + 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (out_ready) begin
          // end is judged on the presented address; fptr may already have wrapped
          if (r_out_addr == r_lreg) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_DONE;
          end else begin
            w_data_nxt = rf_rd;
            w_addr_nxt = r_fptr;
            w_fptr_nxt = r_fptr + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rf_ra     = r_fptr;
  assign busy      = (r_state == ST_FETCH) || (r_state == ST_HOLD);
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader with a behavioural 32x32 register file.
module tb_regfile_dump_reader;

  logic        clk, rst, start, abort, out_ready;
  logic [4:0]  first_reg, last_reg, rf_ra, out_addr;
  logic [31:0] rf_rd, out_data;
  logic        out_valid, busy, done;

  logic [31:0] rf [32];
  assign rf_rd = rf[rf_ra];

  regfile_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .abort(abort), .rf_ra(rf_ra), .rf_rd(rf_rd), .out_addr(out_addr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } word_t;

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         mode;     // 0 ready=1, 1 toggle, 2 random, 3 hold at 18 + write reg 20
    int         exp_cnt;
  } vec_t;

  word_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          words = 0;
  int          done_cnt = 0;
  logic        prev_hold = 1'b0;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;

  function automatic logic [31:0] preload(input int a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pops one expected word per handshake and checks hold stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && out_valid) begin
        chk("hold_addr", 64'(out_addr), 64'(prev_addr));
        chk("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got addr %0d data %0h expected none", out_addr, out_data);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_addr", 64'(out_addr), 64'(w.a));
          chk("word_data", 64'(out_data), 64'(w.d));
        end
        words++;
      end
      if (done) done_cnt++;
      prev_hold = out_valid && !out_ready;
      prev_addr = out_addr;
      prev_data = out_data;
    end
  end

  task automatic push_range(input int f, input int l, input logic wr20);
    for (int a = f; a <= l; a++) begin
      word_t w;
      w.a = 5'(a);
      w.d = (wr20 && a == 20) ? 32'hDEAD_BEEF : preload(a);
      exp_q.push_back(w);
    end
  endtask

  task automatic run_dump(input vec_t v);
    logic wrote;
    wrote = 1'b0;
    push_range(int'(v.first), int'(v.last), v.mode == 3);
    words = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; first_reg = v.first; last_reg = v.last;
    out_ready = (v.mode == 1) ? 1'b0 : 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt > 0) break;
      case (v.mode)
        1: out_ready = (cyc % 2 == 0);
        2: out_ready = 1'($urandom_range(0, 1));
        3: begin
          if (!wrote && out_valid && out_addr == 5'd18) begin
            out_ready = 1'b0;
            @(negedge clk);
            rf[20] = 32'hDEAD_BEEF;
            wrote = 1'b1;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
    chk("dump_done", 64'(done_cnt), 64'd1);
    chk("dump_words", 64'(words), 64'(v.exp_cnt));
    chk("dump_q_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    rf[20] = preload(20);
    out_ready = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = preload(i);
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_reg = '0; last_reg = '0;

    vecs[0] = '{first: 5'd3,  last: 5'd6,  mode: 0, exp_cnt: 4};
    vecs[1] = '{first: 5'd28, last: 5'd31, mode: 1, exp_cnt: 4};
    vecs[2] = '{first: 5'd9,  last: 5'd4,  mode: 0, exp_cnt: 0};
    vecs[3] = '{first: 5'd0,  last: 5'd31, mode: 3, exp_cnt: 32};
    vecs[4] = '{first: 5'd0,  last: 5'd31, mode: 2, exp_cnt: 32};
    vecs[5] = '{first: 5'd31, last: 5'd31, mode: 1, exp_cnt: 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_addr",  64'(out_addr), 64'd0);
    chk("rst_data",  64'(out_data), 64'd0);
    chk("rst_ra",    64'(rf_ra), 64'd0);

    // Cycle-exact timing for first=3,last=6 with ready held high
    push_range(3, 6, 1'b0);
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; first_reg = 5'd3; last_reg = 5'd6; out_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("t1_valid", 64'(out_valid), 64'(c >= 2 && c <= 5));
      chk("t1_busy",  64'(busy), 64'(c <= 5));
      chk("t1_done",  64'(done), 64'(c == 7));
      if (c >= 2 && c <= 5) chk("t1_addr", 64'(out_addr), 64'(c + 1));
    end
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    out_ready = 1'b0;

    // Empty range: done two cycles after start, never busy
    @(posedge clk); #1;
    start = 1'b1; first_reg = 5'd9; last_reg = 5'd4;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("t3_busy",  64'(busy), 64'd0);
      chk("t3_valid", 64'(out_valid), 64'd0);
      chk("t3_done",  64'(done), 64'(c == 2));
    end

    foreach (vecs[i]) run_dump(vecs[i]);

    // Abort while address 5 is held
    push_range(2, 10, 1'b0);
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; first_reg = 5'd2; last_reg = 5'd10; out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!(out_valid && out_addr == 5'd5) && n < 50) begin
        @(posedge clk); #1;
        start = 1'b0;
        n++;
      end
      chk("t5_reach5", 64'(n < 50), 64'd1);
    end
    out_ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_busy",  64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    chk("t5_left", 64'(exp_q.size()), 64'd6);
    exp_q.delete();
    run_dump('{first: 5'd0, last: 5'd0, mode: 0, exp_cnt: 1});

    // Reset mid-dump; start in the reset cycle must be ignored
    push_range(0, 31, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("t6_in_hold", 64'(busy && out_valid), 64'd1);
    rst = 1'b1; start = 1'b1; first_reg = 5'd1; last_reg = 5'd2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    exp_q.delete();
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_addr",  64'(out_addr), 64'd0);
    chk("t6_data",  64'(out_data), 64'd0);
    chk("t6_busy",  64'(busy), 64'd0);
    chk("t6_done",  64'(done), 64'd0);
    chk("t6_ra",    64'(rf_ra), 64'd0);
    @(posedge clk); #1;
    chk("t6_start_ignored", 64'(busy), 64'd0);
    chk("t6_done2", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
